bc_orbit_counter: RTL and testbench
===================================

# bc_orbit_counter

Parametrised bunch/orbit counter that generalises the free-running 12-bit bunch counter. It adds a configurable orbit length, an orbit counter, and lock/resync to an external bunch-zero (BC0) pulse with miss and error supervision. It also captures BC/orbit timestamps on a trigger strobe. It sits at the front of the digitizer timing path and feeds BC/ORBIT tags to the readout and trigger logic.

## Interface
- BC_WIDTH, 12, width of bunch counter; requires BC_MAX < 2^BC_WIDTH
- BC_MAX, 3563, last bunch index in an orbit; period = BC_MAX+1
- BC_OFFSET, 0, value loaded into BC on the cycle after an accepted BC0_IN; requires BC_OFFSET ≤ BC_MAX
- ORBIT_WIDTH, 32, width of orbit counter
- MISS_LIMIT, 3, consecutive missing BC0 pulses that drop lock (≥1)
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, asynchronous, active-high; one clock domain
- EN  input  1  count enable; when low, all counters and the state hold, and BC0_IN is ignored
- BC0_IN  input  1  external bunch-zero strobe, one cycle wide, synchronous to CLK
- TRIG  input  1  timestamp capture strobe
- BC  output  BC_WIDTH  current bunch number
- ORBIT  output  ORBIT_WIDTH  current orbit number
- BC0  output  1  high while LOCKED and BC==0
- LOCKED  output  1  state == LOCKED
- SYNC_ERR  output  1  one-cycle pulse on misaligned BC0_IN while LOCKED
- ERR_CNT  output  8  count of SYNC_ERR events; saturates at 255
- TS_VALID  output  1  one-cycle pulse; TS_BC/TS_ORBIT are updated
- TS_BC  output  BC_WIDTH  captured BC
- TS_ORBIT  output  ORBIT_WIDTH  captured ORBIT

## Operation
- Expected position: E = BC_MAX if BC_OFFSET==0, else BC_OFFSET-1. An aligned BC0_IN arrives while BC==E, so the natural next BC equals BC_OFFSET.
- BC update with EN=1: if BC0_IN is accepted, next BC = BC_OFFSET. Otherwise, next BC = 0 when BC==BC_MAX, else BC+1.
- ORBIT update:
  - Increments (wrapping modulo 2^ORBIT_WIDTH) on every EN cycle with BC==BC_MAX.
  - A first lock (UNLOCKED→LOCKED) clears ORBIT to 0 instead, and this takes priority.
- State machine, two states with a miss counter (width clog2(MISS_LIMIT+1)):
  - UNLOCKED (reset state): BC free-runs. BC0_IN at any BC loads BC_OFFSET, clears ORBIT, clears the miss counter, and moves to LOCKED. No SYNC_ERR is raised.
  - LOCKED, BC0_IN with BC==E: aligned. Clear the miss counter and stay.
  - LOCKED, BC0_IN with BC≠E: misaligned.
    - Load BC_OFFSET, pulse SYNC_ERR, increment ERR_CNT (saturating), clear the miss counter, and stay LOCKED.
    - ORBIT follows the normal wrap rule only.
  - LOCKED, BC==E with no BC0_IN: increment the miss counter. When it reaches MISS_LIMIT, go to UNLOCKED and clear the miss counter. BC keeps free-running.
- Priority: RST > EN low > BC0_IN handling > natural count.
- Timestamp: on any cycle with TRIG=1, independent of EN, capture the current (pre-update) BC and ORBIT. TS_VALID pulses on the following cycle.
  - Back-to-back TRIG cycles each capture, and TS_VALID stays high for each.
  - TS registers hold between captures.

## Timing
- All outputs are registered, except BC0 and LOCKED, which are decoded from registered state with no extra gate delay stages.
- Reset: BC=0, ORBIT=0, LOCKED=0, BC0=0, SYNC_ERR=0, ERR_CNT=0, TS_VALID=0, TS_BC=0, TS_ORBIT=0, state UNLOCKED, miss counter 0.
  - Assertion mid-operation clears everything asynchronously.
  - The first count occurs on the first rising edge after deassertion.
- BC0_IN sampled at edge N: BC=BC_OFFSET after edge N. LOCKED rises after edge N (first lock). SYNC_ERR is high for the cycle after edge N (misaligned case).
- Missing-pulse unlock: LOCKED falls after the edge that samples the MISS_LIMIT-th consecutive BC==E without BC0_IN.
- TRIG sampled at edge N: TS_* are valid and TS_VALID=1 after edge N, for one cycle.
- EN low: BC, ORBIT, state, miss counter and ERR_CNT hold. SYNC_ERR is 0.

## Test plan
- Reset release, EN=1, no BC0_IN, 2×3564 cycles:
  - BC sequence 0,1,…,3563,0.
  - ORBIT is 2 after 7128 cycles.
  - LOCKED=0 throughout.
- BC0_IN at BC=100 while unlocked: next BC=0, ORBIT=0, LOCKED=1, SYNC_ERR=0. Then aligned BC0_IN every 3564 cycles: no SYNC_ERR, ORBIT increments at each BC 3563→0.
- Locked, BC0_IN at BC=2000:
  - Next BC=0, SYNC_ERR=1 for one cycle, ERR_CNT=1, LOCKED stays 1.
  - Repeat 300 times: ERR_CNT=255.
- Locked, BC0_IN withheld: LOCKED=1 after 2 missed orbits, LOCKED=0 right after the 3rd BC==3563 with no pulse. BC continues 0,1,…
- TRIG at BC=42, ORBIT=7, then TRIG on two consecutive cycles:
  - TS_BC=42, TS_ORBIT=7, one-cycle TS_VALID.
  - Then TS_VALID high for 2 cycles with consecutive TS_BC values.
- EN low for 10 cycles mid-orbit, with BC0_IN pulsed during that window: BC/ORBIT frozen and BC0_IN ignored. Then RST pulsed asynchronously mid-cycle: all outputs 0 immediately.

Source files
------------

// File: rtl/bc_orbit_counter.sv
// Bunch/orbit counter with BC0 lock, miss supervision and trigger timestamps.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_UNLOCKED | BC free-runs; the first BC0_IN resyncs BC and clears ORBIT
// ST_LOCKED   | BC0_IN expected at BC==E; misalignment flagged, misses counted
module bc_orbit_counter #(
    parameter int BC_WIDTH    = 12,
    parameter int BC_MAX      = 3563,
    parameter int BC_OFFSET   = 0,
    parameter int ORBIT_WIDTH = 32,
    parameter int MISS_LIMIT  = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   BC0_IN,
    input  logic                   TRIG,
    output logic [BC_WIDTH-1:0]    BC,
    output logic [ORBIT_WIDTH-1:0] ORBIT,
    output logic                   BC0,
    output logic                   LOCKED,
    output logic                   SYNC_ERR,
    output logic [7:0]             ERR_CNT,
    output logic                   TS_VALID,
    output logic [BC_WIDTH-1:0]    TS_BC,
    output logic [ORBIT_WIDTH-1:0] TS_ORBIT
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [BC_WIDTH-1:0] BC_LAST = BC_WIDTH'(BC_MAX);
    localparam logic [BC_WIDTH-1:0] BC_LOAD = BC_WIDTH'(BC_OFFSET);
    // Aligned BC0_IN arrives one bunch before the load value.
    localparam logic [BC_WIDTH-1:0] BC_EXP  = (BC_OFFSET == 0) ? BC_WIDTH'(BC_MAX)
                                                               : BC_WIDTH'(BC_OFFSET - 1);
    localparam logic [MISS_W-1:0]   MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t            state;
    logic [MISS_W-1:0] miss_cnt;

    // Counters, lock state machine, error supervision and timestamp capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_UNLOCKED;
            miss_cnt <= '0;
            BC       <= '0;
            ORBIT    <= '0;
            SYNC_ERR <= 1'b0;
            ERR_CNT  <= '0;
            TS_VALID <= 1'b0;
            TS_BC    <= '0;
            TS_ORBIT <= '0;
        end else begin
            SYNC_ERR <= 1'b0;
            TS_VALID <= TRIG;
            if (TRIG) begin
                TS_BC    <= BC;
                TS_ORBIT <= ORBIT;
            end

            if (EN) begin
                if (BC == BC_LAST) begin
                    BC    <= '0;
                    ORBIT <= ORBIT + ORBIT_WIDTH'(1);
                end else begin
                    BC <= BC + BC_WIDTH'(1);
                end

                case (state)
                    ST_UNLOCKED: begin
                        if (BC0_IN) begin
                            BC       <= BC_LOAD;
                            ORBIT    <= '0;
                            miss_cnt <= '0;
                            state    <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (BC0_IN) begin
                            BC       <= BC_LOAD;
                            miss_cnt <= '0;
                            if (BC != BC_EXP) begin
                                SYNC_ERR <= 1'b1;
                                if (ERR_CNT != 8'hFF)
                                    ERR_CNT <= ERR_CNT + 8'd1;
                            end
                        end else if (BC == BC_EXP) begin
                            if (miss_cnt == MISS_LAST) begin
                                miss_cnt <= '0;
                                state    <= ST_UNLOCKED;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    default: state <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign LOCKED = (state == ST_LOCKED);
    assign BC0    = LOCKED && (BC == '0);

endmodule

// File: tb/tb_bc_orbit_counter.sv
// Randomised and directed bench for bc_orbit_counter against a behavioural model.
module tb_bc_orbit_counter;

    localparam int BCM = 3563;
    localparam int PER = BCM + 1;
    localparam int EXP_POS = BCM;          // offset 0: aligned pulse at last bunch
    localparam int MISSES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        bc0_in;
    logic        trig;
    logic [11:0] bc;
    logic [31:0] orbit;
    logic        bc0;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_cnt;
    logic        ts_valid;
    logic [11:0] ts_bc;
    logic [31:0] ts_orbit;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural reference state (integers, updated from the rules in words).
    int          m_bc, m_miss, m_err;
    logic [31:0] m_orbit, m_tsorb;
    bit          m_locked, m_serr, m_tsv;
    int          m_tsbc;

    bc_orbit_counter dut (
        .CLK(clk), .RST(rst), .EN(en), .BC0_IN(bc0_in), .TRIG(trig),
        .BC(bc), .ORBIT(orbit), .BC0(bc0), .LOCKED(locked),
        .SYNC_ERR(sync_err), .ERR_CNT(err_cnt), .TS_VALID(ts_valid),
        .TS_BC(ts_bc), .TS_ORBIT(ts_orbit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bc = 0; m_orbit = '0; m_locked = 0; m_miss = 0; m_err = 0;
        m_serr = 0; m_tsv = 0; m_tsbc = 0; m_tsorb = '0;
    endtask

    task automatic model_edge(input bit e, input bit p, input bit t);
        int old_bc;
        old_bc = m_bc;
        m_serr = 0;
        m_tsv  = t;
        if (t) begin
            m_tsbc  = m_bc;
            m_tsorb = m_orbit;
        end
        if (e) begin
            m_bc = (old_bc + 1) % PER;
            if (old_bc == BCM) m_orbit = m_orbit + 1;
            if (p && !m_locked) begin
                m_bc = 0; m_orbit = 0; m_locked = 1; m_miss = 0;
            end else if (p) begin
                m_bc = 0; m_miss = 0;
                if (old_bc != EXP_POS) begin
                    m_serr = 1;
                    if (m_err < 255) m_err++;
                end
            end else if (m_locked && old_bc == EXP_POS) begin
                m_miss++;
                if (m_miss == MISSES) begin
                    m_locked = 0; m_miss = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("BC", bc, m_bc);
        chk("ORBIT", orbit, m_orbit);
        chk("LOCKED", locked, m_locked);
        chk("BC0", bc0, (m_locked && m_bc == 0));
        chk("SYNC_ERR", sync_err, m_serr);
        chk("ERR_CNT", err_cnt, m_err);
        chk("TS_VALID", ts_valid, m_tsv);
        chk("TS_BC", ts_bc, m_tsbc);
        chk("TS_ORBIT", ts_orbit, m_tsorb);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit e, input bit p, input bit t);
        en = e; bc0_in = p; trig = t;
        @(posedge clk);
        model_edge(e, p, t);
        #1;
        check_all();
        @(negedge clk);
        en = 1'b1; bc0_in = 1'b0; trig = 1'b0;
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (m_bc != target && guard < 2 * PER) begin
            step(1, 0, 0);
            guard++;
        end
        if (m_bc != target) begin
            n_cmp++; n_mis++;
            $display("FAIL run_until: bc %0d never reached target %0d", m_bc, target);
        end
    endtask

    initial begin
        logic [11:0] frz_bc;
        logic [31:0] frz_orb;
        rst = 1'b1; en = 1'b0; bc0_in = 1'b0; trig = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Free-run two orbits unlocked.
        for (int i = 0; i < 2 * PER; i++) step(1, 0, 0);
        chk("free_orbit2", orbit, 32'd2);
        chk("free_bc0", bc, 12'd0);
        chk("free_unlocked", locked, 1'b0);

        // First lock at BC=100.
        run_until(100);
        step(1, 1, 0);
        chk("lock_bc", bc, 12'd0);
        chk("lock_orbit", orbit, 32'd0);
        chk("lock_locked", locked, 1'b1);
        chk("lock_serr", sync_err, 1'b0);

        // Aligned pulses for three orbits.
        for (int k = 0; k < 3; k++) begin
            run_until(EXP_POS);
            step(1, 1, 0);
            chk("aligned_serr", sync_err, 1'b0);
            chk("aligned_orbit", orbit, 32'(k + 1));
        end

        // Misaligned at BC=2000, then rapid repeats to saturate ERR_CNT.
        run_until(2000);
        step(1, 1, 0);
        chk("mis_bc", bc, 12'd0);
        chk("mis_serr", sync_err, 1'b1);
        chk("mis_errcnt1", err_cnt, 8'd1);
        chk("mis_locked", locked, 1'b1);
        step(1, 0, 0);
        chk("mis_serr_pulse", sync_err, 1'b0);
        for (int k = 0; k < 299; k++) begin
            step(1, 0, 0);
            step(1, 1, 0);
        end
        chk("mis_errcnt_sat", err_cnt, 8'd255);

        // Withhold pulses: survive two misses, drop on the third.
        run_until(EXP_POS);
        step(1, 1, 0);
        for (int i = 0; i < 2 * PER; i++) step(1, 0, 0);
        chk("miss2_locked", locked, 1'b1);
        for (int i = 0; i < PER; i++) step(1, 0, 0);
        chk("miss3_unlocked", locked, 1'b0);
        chk("miss3_bc", bc, 12'd0);
        step(1, 0, 0);
        chk("miss3_freerun", bc, 12'd1);

        // Timestamps: single then back-to-back.
        run_until(42);
        frz_orb = m_orbit;
        step(1, 0, 1);
        chk("ts_bc42", ts_bc, 12'd42);
        chk("ts_orbit", ts_orbit, frz_orb);
        chk("ts_valid1", ts_valid, 1'b1);
        step(1, 0, 0);
        chk("ts_valid_drop", ts_valid, 1'b0);
        step(1, 0, 1);
        chk("ts_b2b_a", ts_bc, 12'd44);
        step(1, 0, 1);
        chk("ts_b2b_b", ts_bc, 12'd45);
        chk("ts_b2b_valid", ts_valid, 1'b1);

        // Randomised traffic: mostly aligned pulses, occasional strays, EN gaps.
        for (int i = 0; i < 15000; i++) begin
            bit e, p, t;
            e = ($urandom_range(0, 9) != 0);
            t = ($urandom_range(0, 19) == 0);
            if (m_bc == EXP_POS) p = ($urandom_range(0, 3) != 0);
            else                 p = ($urandom_range(0, 799) == 0);
            step(e, p, t);
        end

        // EN low for 10 cycles with a BC0_IN inside the window.
        run_until(1234);
        frz_bc = bc;
        frz_orb = orbit;
        for (int i = 0; i < 10; i++) step(0, (i == 4), 0);
        chk("en_low_bc", bc, frz_bc);
        chk("en_low_orbit", orbit, frz_orb);
        step(1, 0, 0);
        chk("en_resume_bc", bc, 12'd1235);

        // Asynchronous reset mid-cycle.
        step(1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0);
        chk("post_rst_bc", bc, 12'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
